// File: rtl/rsa_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rsa_pkg
//   Shared types and constants for the RSA message sequencer slice.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
package rsa_pkg;

   // Default plaintext/ciphertext width of the encryption stage
   localparam int K_DEF        = 8;
   // Shortest enable-low gap that lets the encryption stage re-initialise
   localparam int GAP_MIN      = 4;
   // Default number of RUN cycles before declaring a timeout
   localparam int MAX_WAIT_DEF = 4096;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RUN     = 3'd1,
      EMIT    = 3'd2,
      RECOVER = 3'd3,
      DONE    = 3'd4,
      ERR     = 3'd5
   } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/rsa_msg_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rsa_msg_sequencer_if
//   Encryption-stage handshake plus downstream ciphertext stream.
//   master = sequencer side, slave = encryption stage / downstream side.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
interface rsa_msg_sequencer_if
   import rsa_pkg::*;
#(
   parameter int K  = K_DEF,
   parameter int AW = 4
) ();

   logic          enc_en;
   logic [K-1:0]  enc_a;
   logic          enc_ready;
   logic [K-1:0]  enc_cipher;
   logic          out_valid;
   logic [K-1:0]  out_data;
   logic [AW-1:0] out_idx;
   logic          out_ready;

   modport master (
      output enc_en, enc_a, out_valid, out_data, out_idx,
      input  enc_ready, enc_cipher, out_ready
   );

   modport slave (
      input  enc_en, enc_a, out_valid, out_data, out_idx,
      output enc_ready, enc_cipher, out_ready
   );

endinterface
`default_nettype wire

// File: rtl/rsa_msg_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rsa_msg_ram
//   DEPTH x K message buffer: synchronous write, combinational read.
//   Contents are deliberately not reset.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module rsa_msg_ram
   import rsa_pkg::*;
#(
   parameter int K     = K_DEF,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [K-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [K-1:0]  rdata
);

   logic [K-1:0] mem [DEPTH];

   // Write port: one byte per strobe
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/rsa_msg_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rsa_msg_sequencer
//   Feeds a buffered plaintext message byte by byte into the modular
//   exponentiation stage, forces an enable-low recovery gap between bytes
//   and streams each ciphertext downstream over valid/ready.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module rsa_msg_sequencer
   import rsa_pkg::*;
#(
   parameter int K        = K_DEF,
   parameter int DEPTH    = 16,
   parameter int AW       = 4,
   parameter int GAP      = GAP_MIN,
   parameter int MAX_WAIT = MAX_WAIT_DEF,
   parameter int WW       = 13
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load_we,
   input  logic [AW-1:0]       load_addr,
   input  logic [K-1:0]        load_data,
   input  logic [AW:0]         msg_len,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                err_timeout,
   rsa_msg_sequencer_if.master bus
);

   localparam int            GW        = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [AW:0]   DEPTH_L   = (AW+1)'(DEPTH);
   localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);

   seq_state_t    state, state_n;
   logic [AW-1:0] idx, idx_n;
   logic [AW:0]   len, len_n, len_clamp;
   logic [WW-1:0] wait_cnt, wait_n;
   logic [GW-1:0] gap_cnt, gap_n;
   logic          busy_n, done_n, err_n, valid_n;
   logic [K-1:0]  data_n;
   logic [AW-1:0] oidx_n;
   logic [K-1:0]  rd_data;
   logic          write_en;

   // The buffer is frozen while a message is in flight
   assign write_en  = load_we & ~busy;
   assign len_clamp = (msg_len > DEPTH_L) ? DEPTH_L : msg_len;

   // Read address follows the next index so enc_a is loaded on RUN entry
   rsa_msg_ram #(
      .K     (K),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (write_en),
      .waddr (load_addr),
      .wdata (load_data),
      .raddr (idx_n),
      .rdata (rd_data)
   );

   // Next-state and next-output decode
   always_comb begin
      state_n = state;
      idx_n   = idx;
      len_n   = len;
      wait_n  = wait_cnt;
      gap_n   = gap_cnt;
      busy_n  = busy;
      done_n  = 1'b0;
      err_n   = err_timeout;
      valid_n = bus.out_valid;
      data_n  = bus.out_data;
      oidx_n  = bus.out_idx;
      case (state)
         IDLE: begin
            if (start) begin
               len_n   = len_clamp;
               err_n   = 1'b0;
               idx_n   = '0;
               wait_n  = '0;
               busy_n  = 1'b1;
               state_n = (len_clamp == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            wait_n = wait_cnt + 1'b1;
            // Ready takes priority over a coincident timeout
            if (bus.enc_ready) begin
               data_n  = bus.enc_cipher;
               oidx_n  = idx;
               valid_n = 1'b1;
               state_n = EMIT;
            end else if (wait_cnt == WAIT_LAST) begin
               err_n   = 1'b1;
               busy_n  = 1'b0;
               state_n = ERR;
            end
         end
         EMIT: begin
            if (bus.out_ready) begin
               valid_n = 1'b0;
               if ({1'b0, idx} == (len - 1'b1)) begin
                  busy_n  = 1'b0;
                  state_n = DONE;
               end else begin
                  idx_n   = idx + 1'b1;
                  gap_n   = '0;
                  state_n = RECOVER;
               end
            end
         end
         RECOVER: begin
            if (gap_cnt == GAP_LAST) begin
               wait_n  = '0;
               state_n = RUN;
            end else begin
               gap_n = gap_cnt + 1'b1;
            end
         end
         DONE: begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
         end
         ERR: begin
            busy_n  = 1'b0;
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State and registered outputs; reset aborts any message immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         idx           <= '0;
         len           <= '0;
         wait_cnt      <= '0;
         gap_cnt       <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err_timeout   <= 1'b0;
         bus.enc_en    <= 1'b0;
         bus.enc_a     <= '0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         bus.out_idx   <= '0;
      end else begin
         state         <= state_n;
         idx           <= idx_n;
         len           <= len_n;
         wait_cnt      <= wait_n;
         gap_cnt       <= gap_n;
         busy          <= busy_n;
         done          <= done_n;
         err_timeout   <= err_n;
         bus.enc_en    <= (state_n == RUN);
         if (state_n == RUN) begin
            bus.enc_a <= rd_data;
         end
         bus.out_valid <= valid_n;
         bus.out_data  <= data_n;
         bus.out_idx   <= oidx_n;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rsa_msg_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rsa_msg_sequencer
//   Self-checking bench: RSA stage model (n=33, e=3, 40-cycle latency),
//   expected-ciphertext scoreboard and randomized backpressure.
//   Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_rsa_msg_sequencer;
   import rsa_pkg::*;

   localparam int K        = 8;
   localparam int DEPTH    = 16;
   localparam int AW       = 4;
   localparam int GAP      = 4;
   localparam int MAX_WAIT = 64;
   localparam int WW       = 13;
   localparam int LAT      = 40;
   localparam int MODN     = 33;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          load_we;
   logic [AW-1:0] load_addr;
   logic [K-1:0]  load_data;
   logic [AW:0]   msg_len;
   logic          start;
   logic          busy, done, err_timeout;

   rsa_msg_sequencer_if #(.K(K), .AW(AW)) bus ();

   rsa_msg_sequencer #(
      .K(K), .DEPTH(DEPTH), .AW(AW), .GAP(GAP), .MAX_WAIT(MAX_WAIT), .WW(WW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_we     (load_we),
      .load_addr   (load_addr),
      .load_data   (load_data),
      .msg_len     (msg_len),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .err_timeout (err_timeout),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // ---------------- reference model ----------------
   typedef struct { int data; int idx; } exp_t;
   exp_t     exp_q[$];
   int       model_mem [DEPTH];
   bit       never_ready;
   int       bp_pct;
   int       stall_idx, stall_len;
   int       hs_count = 0, done_count = 0, en_rises = 0;
   int       hs_base, done_base, rise_base;

   function automatic int cube_mod(input int a);
      return (a * a * a) % MODN;
   endfunction

   // Encryption stage: ready LAT cycles after enable, cleared when enable drops
   int enc_cnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enc_cnt        <= 0;
         bus.enc_ready  <= 1'b0;
         bus.enc_cipher <= '0;
      end else if (!bus.enc_en) begin
         enc_cnt       <= 0;
         bus.enc_ready <= 1'b0;
      end else if (!never_ready) begin
         if (enc_cnt == LAT - 1) begin
            bus.enc_ready  <= 1'b1;
            bus.enc_cipher <= K'(cube_mod(int'(bus.enc_a)));
         end else begin
            enc_cnt <= enc_cnt + 1;
         end
      end
   end

   // Downstream sink and monitor, sampled on the falling edge
   initial begin
      bit            holding;
      bit            en_prev;
      int            low_run;
      int            stall_cnt;
      logic [K-1:0]  hold_data;
      logic [AW-1:0] hold_idx;
      exp_t          e;
      holding = 0; en_prev = 0; low_run = 0; stall_cnt = 0;
      bus.out_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            holding = 0; en_prev = 0; low_run = 0;
            bus.out_ready = 1'b0;
         end else begin
            if (holding) begin
               check("hold_valid", bus.out_valid, 1);
               check("hold_data", bus.out_data, hold_data);
               check("hold_idx", bus.out_idx, hold_idx);
               check("hold_en_low", bus.enc_en, 0);
            end
            if (bus.enc_en) begin
               if (!en_prev) begin
                  if (hs_count > hs_base) check("enc_gap", low_run >= GAP, 1);
                  en_rises++;
               end
               low_run = 0;
            end else begin
               low_run++;
            end
            en_prev = bus.enc_en;
            if (done) done_count++;
            if (bus.out_valid && int'(bus.out_idx) == stall_idx && stall_cnt < stall_len) begin
               bus.out_ready = 1'b0;
               stall_cnt++;
            end else begin
               bus.out_ready = ($urandom_range(0, 99) >= bp_pct);
            end
            if (bus.out_valid && bus.out_ready) begin
               hs_count++;
               holding = 0;
               if (exp_q.size() == 0) begin
                  check("extra_out", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("out_data", bus.out_data, e.data);
                  check("out_idx", bus.out_idx, e.idx);
               end
            end else begin
               holding   = bus.out_valid;
               hold_data = bus.out_data;
               hold_idx  = bus.out_idx;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic load_byte(input int addr, input int data);
      @(negedge clk);
      load_we = 1'b1; load_addr = AW'(addr); load_data = K'(data);
      model_mem[addr] = data;
      @(negedge clk);
      load_we = 1'b0;
   endtask

   task automatic outs_zero(input string p);
      check({p, "_busy"}, busy, 0);
      check({p, "_done"}, done, 0);
      check({p, "_err"}, err_timeout, 0);
      check({p, "_enc_en"}, bus.enc_en, 0);
      check({p, "_enc_a"}, bus.enc_a, 0);
      check({p, "_valid"}, bus.out_valid, 0);
      check({p, "_data"}, bus.out_data, 0);
      check({p, "_idx"}, bus.out_idx, 0);
   endtask

   task automatic run_msg(input int len, input bit expect_timeout);
      int eff, cyc, en_first, err_first;
      exp_t e;
      eff = (len > DEPTH) ? DEPTH : len;
      exp_q.delete();
      if (!expect_timeout) begin
         for (int i = 0; i < eff; i++) begin
            e.data = cube_mod(model_mem[i]);
            e.idx  = i;
            exp_q.push_back(e);
         end
      end
      hs_base = hs_count; done_base = done_count; rise_base = en_rises;
      @(negedge clk);
      msg_len = (AW+1)'(len); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1; en_first = -1; err_first = -1;
      check("busy_on_start", busy, 1);
      check("err_cleared", err_timeout, 0);
      while (cyc < 3000) begin
         if (bus.enc_en && en_first < 0) en_first = cyc;
         if (err_timeout && err_first < 0) err_first = cyc;
         if (done || err_first >= 0) break;
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 3000) check("run_bound", 0, 1);
      if (expect_timeout) begin
         check("err_set", err_timeout, 1);
         check("timeout_cycles", err_first - en_first, MAX_WAIT);
         check("busy_after_err", busy, 0);
         repeat (3) @(negedge clk);
         check("err_sticky", err_timeout, 1);
         check("no_done", done_count - done_base, 0);
         check("no_out", hs_count - hs_base, 0);
      end else begin
         check("busy_at_done", busy, 0);
         if (eff == 0) begin
            check("zero_latency", cyc, 2);
            check("zero_no_en", en_rises - rise_base, 0);
         end
         repeat (3) @(negedge clk);
         check("done_once", done_count - done_base, 1);
         check("hs_count", hs_count - hs_base, eff);
         check("q_empty", exp_q.size(), 0);
      end
   endtask

   task automatic disturb();
      for (int i = 0; i < 200 && !busy; i++) @(negedge clk);
      for (int i = 0; i < 2000 && (hs_count - hs_base) < 1; i++) @(negedge clk);
      @(negedge clk);
      check("disturb_busy", busy, 1);
      load_we = 1'b1; load_addr = AW'(1); load_data = 8'h77;
      start = 1'b1; msg_len = (AW+1)'(1);
      @(negedge clk);
      load_we = 1'b0; start = 1'b0;
   endtask

   task automatic reset_mid_run();
      exp_t e;
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         e.data = cube_mod(model_mem[i]); e.idx = i;
         exp_q.push_back(e);
      end
      hs_base = hs_count;
      @(negedge clk);
      msg_len = (AW+1)'(3); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 2000 && !((hs_count - hs_base) >= 1 && bus.enc_en); i++) @(negedge clk);
      check("mid_reached_run1", (hs_count - hs_base) >= 1 && bus.enc_en, 1);
      #3 rst_n = 1'b0;
      #1 outs_zero("mid_rst");
      @(negedge clk);
      @(negedge clk);
      exp_q.delete();
      rst_n = 1'b1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst_n = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
      msg_len = '0; start = 1'b0; never_ready = 0; bp_pct = 0;
      stall_idx = 0; stall_len = 0; hs_base = 0; done_base = 0; rise_base = 0;
      repeat (3) @(negedge clk);
      outs_zero("reset");
      rst_n = 1'b1;

      // Basic run: {2,4,5} -> (8,0) (31,1) (26,2)
      load_byte(0, 2); load_byte(1, 4); load_byte(2, 5);
      run_msg(3, 0);

      // Long backpressure on byte 1
      stall_idx = 1; stall_len = 20;
      run_msg(3, 0);
      stall_len = 0;

      // Zero length
      run_msg(0, 0);

      // Timeout, then a start that clears the sticky flag
      never_ready = 1;
      run_msg(2, 1);
      never_ready = 0;
      run_msg(1, 0);

      // start and load while busy are ignored; buffer unchanged afterwards
      fork
         run_msg(3, 0);
         disturb();
      join
      run_msg(3, 0);

      // Asynchronous reset during RUN of byte 1
      reset_mid_run();
      run_msg(3, 0);

      // Length clamp with random content and backpressure
      for (int i = 0; i < DEPTH; i++) load_byte(i, int'($urandom_range(0, 255)));
      bp_pct = 30;
      run_msg(20, 0);

      // Random messages
      repeat (4) begin
         for (int i = 0; i < DEPTH; i++) load_byte(i, int'($urandom_range(0, 255)));
         bp_pct = int'($urandom_range(0, 60));
         run_msg(int'($urandom_range(0, 20)), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_checks);
      $fatal(1);
   end

endmodule
`default_nettype wire
